// File: rtl/decoder_sel_seq.sv
// Registered one-hot select generator with LEVEL / PULSE / SCAN / CLEAR commands,
// out-of-range flagging and busy status. The last accepted command always wins.
module decoder_sel_seq #(
    parameter int SEL_W     = 5,
    parameter int OUT_W     = 32,
    parameter int PULSE_LEN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] O,
    output logic [SEL_W-1:0] idx,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = $clog2(PULSE_LEN + 1);
    localparam logic [1:0] M_LEVEL = 2'b00;
    localparam logic [1:0] M_PULSE = 2'b01;
    localparam logic [1:0] M_SCAN  = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;
    localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(PULSE_LEN - 1);

    typedef enum logic [1:0] {IDLE, HOLD, PULSE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] o_q, o_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_oor;

    assign sel_oor = (int'(sel) >= OUT_W);

    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (en) begin
            err_d = 1'b0;
            if (load) begin
                if (mode == M_CLEAR || sel_oor) begin
                    state_d = IDLE;
                    o_d     = '0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    err_d   = (mode != M_CLEAR);
                end else begin
                    o_d   = OUT_W'(1) << sel;
                    idx_d = sel;
                    cnt_d = '0;
                    case (mode)
                        M_LEVEL: begin
                            state_d = HOLD;
                            busy_d  = 1'b0;
                        end
                        M_PULSE: begin
                            state_d = PULSE;
                            busy_d  = 1'b1;
                            cnt_d   = CNT_START;
                        end
                        default: begin
                            state_d = SCAN;
                            busy_d  = 1'b1;
                        end
                    endcase
                end
            end else begin
                case (state_q)
                    PULSE: begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end else begin
                            state_d = IDLE;
                            o_d     = '0;
                            idx_d   = '0;
                            busy_d  = 1'b0;
                        end
                    end
                    SCAN: begin
                        // Rotation keeps O one-hot across the wrap for any OUT_W.
                        o_d   = {o_q[OUT_W-2:0], o_q[OUT_W-1]};
                        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + SEL_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            o_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign O    = o_q;
    assign idx  = idx_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: doc/decoder_sel_seq.md
Name: decoder_sel_seq

Overview:
- Parametrised, registered N-to-OUT_W one-hot select generator.
- Successor to the combinational 5-to-32 decoder used for register-file and peripheral selects in the CPU.
- Adds a load/enable command interface, three output modes (level, timed pulse, auto-scan), out-of-range detection and status outputs.
- Sits between the control unit and write-enable / chip-select fan-out.

Parameters:
- SEL_W, 5: select index width.
- OUT_W, 32: number of one-hot outputs. Legal range 2..2^SEL_W. Indices >= OUT_W are out of range.
- PULSE_LEN, 1: output width in cycles for PULSE mode. Must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  clock enable. When 0, all state and outputs hold and load is ignored.
- load  in  1  command strobe, sampled on a rising clk edge when en=1.
- mode  in  2  command: 00 LEVEL, 01 PULSE, 10 SCAN, 11 CLEAR. Sampled only with load.
- sel  in  SEL_W  start/target index, sampled only with load.
- O  out  OUT_W  registered one-hot (or all-zero) select.
- idx  out  SEL_W  index of the asserted O bit; 0 when O is all-zero.
- busy  out  1  high while in PULSE or SCAN.
- err  out  1  one-cycle flag: the last accepted load had sel >= OUT_W (modes 00/01/10 only).

Behaviour:
- Reset (async, rst_n=0): O=0, idx=0, busy=0, err=0, state=IDLE, pulse counter=0. Outputs clear immediately, not on the next edge. Release is synchronous to the next edge; no command is accepted on the release edge's prior value.
- All outputs are registered. Latency from an accepted load to O/idx/busy/err update is 1 cycle.
- States: IDLE, HOLD, PULSE, SCAN.
- Command acceptance: load=1 and en=1. The last command always wins: a new load aborts any PULSE or SCAN in progress and is applied on that edge.
- Range check: if sel >= OUT_W with mode 00/01/10, the next cycle has O=0, idx=0, busy=0, err=1, state=IDLE. err is 0 on every other cycle.
- LEVEL (00): O=onehot(sel), idx=sel, state HOLD, busy=0. Held indefinitely until the next load.
- PULSE (01): O=onehot(sel), idx=sel, busy=1, counter loaded with PULSE_LEN-1.
  - Each en cycle with counter>0: decrement.
  - On the en cycle with counter=0: next cycle O=0, idx=0, busy=0, state IDLE.
  - O is therefore high for exactly PULSE_LEN en-cycles.
- SCAN (10): O=onehot(sel), idx=sel, busy=1.
  - Each subsequent en cycle without load: idx advances by 1 and O moves with it.
  - idx = OUT_W-1 wraps to 0, also when OUT_W is not a power of 2.
  - Runs until the next load.
- CLEAR (11): O=0, idx=0, busy=0, state IDLE. sel is ignored and err=0.
- en=0 freezes the scan position, the pulse counter and all outputs. err, if set, stays high for that frozen cycle and clears on the next en cycle.
- Invariant: O has at most one bit set in every cycle, including across aborts and wrap.
- Arithmetic: idx increment is modulo OUT_W. Counter width is clog2(PULSE_LEN+1).

Test Plan:
- Reset/LEVEL, defaults: assert rst_n=0 mid-SCAN -> O=0, busy=0 immediately. Release, then load mode=00 sel=5 -> next cycle O=32'h0000_0020, idx=5, busy=0, held for 10 cycles.
- PULSE, PULSE_LEN=3: load mode=01 sel=31 -> O=32'h8000_0000 for exactly 3 cycles with busy=1, then O=0, busy=0. Repeat with en=0 for 2 cycles mid-pulse -> O high for 5 cycles total.
- SCAN wrap, OUT_W=20, SEL_W=5: load mode=10 sel=18 -> idx sequence 18,19,0,1. O one-hot at each step. Second load mode=11 -> O=0, busy=0 the next cycle.
- Out of range, OUT_W=20: load mode=00 sel=25 -> O=0, err=1 for one cycle, then err=0. Load mode=11 sel=25 -> err stays 0.
- Abort/retrigger: during PULSE (PULSE_LEN=4, cycle 2), load mode=00 sel=3 -> next cycle O=8, busy=0, no residual pulse. During SCAN, load mode=01 -> pulse restarts at the new sel.
- Random: 2000 cycles of random en/load/mode/sel -> scoreboard matches, and $countones(O)<=1 every cycle.
